// File: rtl/counter_axil_arbiter.sv
//------------------------------------------------------------------------------
// counter_axil_arbiter - round-robin req/ack requesters onto one AXI4-Lite master
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module counter_axil_arbiter #(
    parameter int NUM_REQ            = 2,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETN,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ-1:0]                    req_we,
    input  logic [NUM_REQ*4-1:0]                  req_addr,
    input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                    ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                            rsp_resp,
    output logic                                  busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic [2:0]                            M_AXI_AWPROT,
    output logic                                  M_AXI_AWVALID,
    input  logic                                  M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
    output logic                                  M_AXI_WVALID,
    input  logic                                  M_AXI_WREADY,
    input  logic [1:0]                            M_AXI_BRESP,
    input  logic                                  M_AXI_BVALID,
    output logic                                  M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic [2:0]                            M_AXI_ARPROT,
    output logic                                  M_AXI_ARVALID,
    input  logic                                  M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                            M_AXI_RRESP,
    input  logic                                  M_AXI_RVALID,
    output logic                                  M_AXI_RREADY
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                ptr_q, ptr_d;
    logic [IDX_W-1:0]                grant_q, grant_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;

    logic [IDX_W-1:0]                w_win;
    logic                            w_any_req;
    logic [1:0]                      w_word;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_wdata;
    logic                            w_aw_hs;
    logic                            w_w_hs;

    // First active request at or after the priority pointer, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        w_win     = '0;
        w_any_req = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!w_any_req && req[IDX_W'(j)]) begin
                w_any_req = 1'b1;
                w_win     = IDX_W'(j);
            end
        end
    end

    // Only the word index is kept: byte-offset bits are dropped on the bus.
    assign w_word  = req_addr[{w_win, 2'b10} +: 2];
    assign w_wdata = req_wdata[{w_win, 5'b00000} +: C_M_AXI_DATA_WIDTH];
    assign w_aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_w_hs  = wvalid_q & M_AXI_WREADY;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;
        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    grant_d = w_win;
                    ptr_d   = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                    if (req_we[w_win]) begin
                        awaddr_d       = '0;
                        awaddr_d[3:2]  = w_word;
                        wdata_d        = w_wdata;
                        awvalid_d      = 1'b1;
                        wvalid_d       = 1'b1;
                        state_d        = S_WR_ADDR;
                    end else begin
                        araddr_d       = '0;
                        araddr_d[3:2]  = w_word;
                        arvalid_d      = 1'b1;
                        state_d        = S_RD_ADDR;
                    end
                end
            end
            S_WR_ADDR: begin
                if (w_aw_hs) begin
                    awvalid_d = 1'b0;
                end
                if (w_w_hs) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || w_aw_hs) && (!wvalid_q || w_w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d   = 1'b0;
                    rsp_data_d = '0;
                    rsp_resp_d = M_AXI_BRESP;
                    state_d    = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_d   = 1'b0;
                    rsp_data_d = M_AXI_RDATA;
                    rsp_resp_d = M_AXI_RRESP;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_resp_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            wdata_q    <= wdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == S_DONE) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign rsp_data      = rsp_data_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

`default_nettype wire

// File: doc/counter_axil_arbiter.md
# counter_axil_arbiter

AXI4-Lite master that shares the register interface of `counter_general_ip` between several on-chip requesters. Each requester issues single-word register read or write commands over a simple req/ack port. The block arbitrates round-robin, runs one AXI4-Lite transaction at a time against the counter IP's four 32-bit registers at byte offsets 0x0, 0x4, 0x8 and 0xC, and returns read data and response to the granted requester. It sits between the control logic and the `S00_AXI` slave port of the counter IP.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `C_M_AXI_ADDR_WIDTH`, default 4: AXI address width.
- `C_M_AXI_DATA_WIDTH`, default 32: AXI data width, fixed at 32.

Ports:
- Clock and reset: one clock, `ACLK`. Reset is `ARESETN`, asynchronous and active-low.
- `ACLK`  in  1  clock.
- `ARESETN`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  per-requester command request; held high until `ack`.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*4  packed byte addresses; requester i uses bits [4i+3:4i].
- `req_wdata`  in  NUM_REQ*32  packed write data.
- `ack`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `rsp_data`  out  32  read data; valid while `ack` is high.
- `rsp_resp`  out  2  captured BRESP or RRESP; valid while `ack` is high.
- `busy`  out  1  high from grant until the cycle after `ack`.
- `M_AXI_AWADDR`/`AWPROT`/`AWVALID`  out  4/3/1; `M_AXI_AWREADY`  in  1.
- `M_AXI_WDATA`/`WSTRB`/`WVALID`  out  32/4/1; `M_AXI_WREADY`  in  1.
- `M_AXI_BRESP`  in  2; `M_AXI_BVALID`  in  1; `M_AXI_BREADY`  out  1.
- `M_AXI_ARADDR`/`ARPROT`/`ARVALID`  out  4/3/1; `M_AXI_ARREADY`  in  1.
- `M_AXI_RDATA`  in  32; `M_AXI_RRESP`  in  2; `M_AXI_RVALID`  in  1; `M_AXI_RREADY`  out  1.

## Operation
- FSM states:
  - IDLE: if any `req` is high, grant one requester, latch its we/addr/wdata, then go to WR_ADDR if we=1, else RD_ADDR.
  - WR_ADDR: AWVALID and WVALID rise together. Each drops independently on its own handshake. When both handshakes are done, go to WR_RESP.
  - WR_RESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
  - RD_ADDR: ARVALID=1 until ARREADY, then go to RD_DATA.
  - RD_DATA: RREADY=1. On RVALID, capture RDATA and RRESP and go to DONE.
  - DONE: `ack[grant]`=1 for one cycle, then go to IDLE.
- Arbitration is round-robin with a priority pointer, reset value 0. After each grant to i, the pointer becomes (i+1) mod NUM_REQ. Requests are only sampled in IDLE.
- Bus address = latched addr with bits [1:0] forced to 0. WSTRB=4'hF. AWPROT=ARPROT=3'b000.
- Write responses leave `rsp_data` at 0. `rsp_resp` is passed through unchanged; SLVERR and DECERR are not retried.
- A requester that drops `req` before `ack` does not abort a granted transaction; the `ack` is still issued.

## Timing
- Reset values: all VALID and READY outputs 0, AWADDR/ARADDR/WDATA 0, `ack` 0, `rsp_data` 0, `rsp_resp` 0, `busy` 0, FSM in IDLE, pointer 0.
- Reset asserted mid-transaction clears all outputs immediately and asynchronously. No `ack` is issued. The slave is expected to be reset by the same `ARESETN`.
- Minimum latency with zero-wait slave: `req` sampled at edge 0, VALIDs high in cycle 1, response in cycle 2, `ack` in cycle 3. The next grant can occur at the earliest in cycle 4.
- All AXI outputs are registered. VALID never drops before its READY handshake. Address and data stay stable while VALID is high.
- Simultaneous AWREADY and WREADY in the same cycle completes both handshakes.
- If BVALID or RVALID arrives in the same cycle as the last address handshake, it is not accepted until the next state. BREADY and RREADY are low during the address phase.

## Test plan
- Write reg 1: requester 0 writes addr 0x4, data 0xA5A5_0001 with a zero-wait slave. Required: AWADDR=0x4, WSTRB=0xF, `ack[0]` 3 cycles after sampling, `rsp_resp`=0.
- Read-back: requester 1 writes 0x1..0x4 to offsets 0x0..0xC, then reads all four. Required: `rsp_data` matches each write; `ack` pulses only on bit 1.
- Contention: both `req` held high for 4 commands. Required: grant order 0,1,0,1; every `ack` is exactly one cycle; `busy` low for one cycle between commands.
- Back-pressure: AWREADY delayed 5 cycles, WREADY immediate. Required: WVALID drops after 1 cycle, AWVALID holds with a stable address for 5 cycles, then a single BREADY handshake.
- Error: slave returns RRESP=2'b10 with RDATA=0xDEAD_BEEF. Required: `rsp_resp`=2'b10 and `rsp_data`=0xDEAD_BEEF at `ack`.
- Reset mid-op: deassert `ARESETN` while in WR_RESP. Required: all outputs 0 in the same cycle; no `ack`; after release, a new request from requester 1 is granted first only if requester 0 is idle.
